// File: rtl/pet_core.sv
// Virtual-pet core: tick prescaler, LFSR-driven stat decay, per-stat care and a mood FSM.
// Stats, mood, tick, alarm and age all come straight from flops.
module pet_core #(
    parameter int          N_STATS    = 6,
    parameter int          STAT_W     = 4,
    parameter logic [23:0] MAX_COUNT  = 24'd10_000_000,
    parameter int          CARE_STEP  = 3,
    parameter int          LOW_TH     = 4,
    parameter int          CRIT_TICKS = 8,
    parameter int          DECAY_MODE = 1,
    parameter logic [15:0] SEED       = 16'h1000,
    parameter logic [15:0] TAPS       = 16'hB400
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_STATS-1:0]          care_req,
    output logic [N_STATS*STAT_W-1:0]   stat_bus,
    output logic [1:0]                  mood,
    output logic                        tick,
    output logic                        alarm,
    output logic [7:0]                  age
);

    typedef enum logic [1:0] {
        MOOD_OK   = 2'd0,
        MOOD_WARN = 2'd1,
        MOOD_CRIT = 2'd2,
        MOOD_DEAD = 2'd3
    } mood_e;

    localparam int                SUM_W     = STAT_W + 2;
    localparam int                ZC_W      = $clog2(CRIT_TICKS + 1);
    localparam logic [STAT_W-1:0] STAT_MAX  = '1;
    localparam logic [15:0]       LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [23:0]                      cnt_q, cnt_d;
    logic [15:0]                      lfsr_q, lfsr_d, lfsr_adv;
    logic [N_STATS-1:0][STAT_W-1:0]   stat_q, stat_d;
    mood_e                            state_q, state_d;
    logic [ZC_W-1:0]                  zc_q, zc_d;
    logic [7:0]                       age_q, age_d;
    logic                             tick_q, alarm_q, alarm_d;
    logic                             tick_now, alive, any_zero, any_low;
    logic [N_STATS-1:0]               mask;

    assign tick_now = (cnt_q == MAX_COUNT - 24'd1);
    assign alive    = (state_q != MOOD_DEAD);
    assign cnt_d    = tick_now ? 24'd0 : cnt_q + 24'd1;
    assign mask     = (DECAY_MODE == 0) ? {N_STATS{1'b1}} : lfsr_q[N_STATS-1:0];
    assign lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        lfsr_d = lfsr_q;
        if (tick_now && alive) begin
            lfsr_d = (lfsr_adv == 16'h0000) ? 16'h0001 : lfsr_adv;
        end
    end

    // Stats update every clock; the wide sum lets underflow show up as a set MSB.
    always_comb begin
        stat_d   = stat_q;
        any_zero = 1'b0;
        any_low  = 1'b0;
        for (int i = 0; i < N_STATS; i++) begin : g_stat
            logic [SUM_W-1:0] sum;
            sum = SUM_W'(stat_q[i]);
            if (care_req[i]) begin
                sum = sum + SUM_W'(CARE_STEP);
            end
            if (tick_now && mask[i]) begin
                sum = sum - SUM_W'(1);
            end
            if (alive) begin
                if (sum[SUM_W-1]) begin
                    stat_d[i] = '0;
                end else if (sum > SUM_W'(STAT_MAX)) begin
                    stat_d[i] = STAT_MAX;
                end else begin
                    stat_d[i] = sum[STAT_W-1:0];
                end
            end
            if (stat_d[i] == '0) begin
                any_zero = 1'b1;
            end
            if (int'(stat_d[i]) < LOW_TH) begin
                any_low = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        zc_d    = zc_q;
        age_d   = age_q;
        alarm_d = 1'b0;
        if (tick_now && alive) begin
            if (age_q != 8'hFF) begin
                age_d = age_q + 8'd1;
            end
            case (state_q)
                MOOD_CRIT: begin
                    if (any_zero) begin
                        zc_d = zc_q + 1'b1;
                        if (zc_q == ZC_W'(CRIT_TICKS - 1)) begin
                            state_d = MOOD_DEAD;
                        end
                    end else begin
                        zc_d    = '0;
                        state_d = any_low ? MOOD_WARN : MOOD_OK;
                    end
                end
                default: begin
                    if (any_zero) begin
                        state_d = MOOD_CRIT;
                        zc_d    = '0;
                        alarm_d = 1'b1;
                    end else begin
                        state_d = any_low ? MOOD_WARN : MOOD_OK;
                    end
                end
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            lfsr_q  <= LFSR_INIT;
            stat_q  <= '1;
            state_q <= MOOD_OK;
            zc_q    <= '0;
            age_q   <= '0;
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            stat_q  <= stat_d;
            state_q <= state_d;
            zc_q    <= zc_d;
            age_q   <= age_d;
            tick_q  <= tick_now;
            alarm_q <= alarm_d;
        end
    end

    assign stat_bus = stat_q;
    assign mood     = state_q;
    assign tick     = tick_q;
    assign alarm    = alarm_q;
    assign age      = age_q;

endmodule

// File: tb/tb_pet_core.sv
// Bench for pet_core: two instances (plain decay, LFSR decay with SEED=0) against a
// per-clock integer model; expected snapshots are queued per tick and popped by monitors.
module tb_pet_core;

    localparam int          N     = 6;
    localparam int          W     = 4;
    localparam int          MAXC  = 4;
    localparam int          STEP  = 3;
    localparam int          LOWT  = 4;
    localparam int          CRITT = 8;
    localparam int          SMAX  = 15;
    localparam logic [15:0] TAPS  = 16'hB400;
    localparam int OK = 0, WARN = 1, CRIT = 2, DEAD = 3;

    typedef struct packed {
        logic [N*W-1:0] bus;
        logic [1:0]     mood;
        logic [7:0]     age;
        logic           alarm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] care0 = '0, care1 = '0;
    logic [N*W-1:0] bus0, bus1;
    logic [1:0] mood0, mood1;
    logic tick0, tick1, alarm0, alarm1;
    logic [7:0] age0, age1;

    always #5 clk = ~clk;

    pet_core #(.MAX_COUNT(24'd4), .DECAY_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .care_req(care0), .stat_bus(bus0),
        .mood(mood0), .tick(tick0), .alarm(alarm0), .age(age0));

    pet_core #(.MAX_COUNT(24'd4), .DECAY_MODE(1), .SEED(16'h0000)) dut1 (
        .clk(clk), .reset(reset), .care_req(care1), .stat_bus(bus1),
        .mood(mood1), .tick(tick1), .alarm(alarm1), .age(age1));

    int total = 0;
    int bad = 0;
    int alarms0 = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int          m_stat[2][N];
    int          m_mood[2], m_age[2], m_zc[2];
    logic [15:0] m_lfsr[2];
    int          m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) m_stat[k][i] = SMAX;
            m_mood[k] = OK;
            m_age[k]  = 0;
            m_zc[k]   = 0;
        end
        m_lfsr[0] = 16'h1000;
        m_lfsr[1] = 16'h0001;
        m_cnt = 0;
    endtask

    task automatic step_one(input int k, input logic [N-1:0] c, input bit tk);
        logic [N-1:0] mask;
        int v;
        bit zero, low, al;
        exp_t e;
        al = 1'b0;
        if (m_mood[k] != DEAD) begin
            mask = (k == 0) ? {N{1'b1}} : m_lfsr[k][N-1:0];
            for (int i = 0; i < N; i++) begin
                v = m_stat[k][i] + (c[i] ? STEP : 0) - ((tk && mask[i]) ? 1 : 0);
                if (v < 0) v = 0;
                if (v > SMAX) v = SMAX;
                m_stat[k][i] = v;
            end
            if (tk) begin
                if (m_lfsr[k] % 2 == 1) m_lfsr[k] = (m_lfsr[k] / 2) ^ TAPS;
                else m_lfsr[k] = m_lfsr[k] / 2;
                if (m_lfsr[k] == 0) m_lfsr[k] = 16'h0001;
                if (m_age[k] < 255) m_age[k]++;
                zero = 1'b0;
                low  = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (m_stat[k][i] == 0) zero = 1'b1;
                    if (m_stat[k][i] < LOWT) low = 1'b1;
                end
                if (m_mood[k] == CRIT) begin
                    if (zero) begin
                        m_zc[k]++;
                        if (m_zc[k] >= CRITT) m_mood[k] = DEAD;
                    end else begin
                        m_zc[k] = 0;
                        m_mood[k] = low ? WARN : OK;
                    end
                end else if (zero) begin
                    m_mood[k] = CRIT;
                    m_zc[k] = 0;
                    al = 1'b1;
                end else begin
                    m_mood[k] = low ? WARN : OK;
                end
            end
        end
        if (tk) begin
            e.bus = '0;
            for (int i = 0; i < N; i++) e.bus[i*W +: W] = W'(m_stat[k][i]);
            e.mood  = 2'(m_mood[k]);
            e.age   = 8'(m_age[k]);
            e.alarm = al;
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    // Drive one clock's care pulses and advance the model for the coming edge.
    task automatic cycle(input logic [N-1:0] c0, input logic [N-1:0] c1);
        bit tk;
        care0 = c0;
        care1 = c1;
        tk = (m_cnt == MAXC - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        step_one(0, c0, tk);
        step_one(1, c1, tk);
        @(negedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        repeat (n * MAXC) cycle('0, '0);
    endtask

    // Reset is raised between edges so the checks below see its asynchronous effect.
    task automatic do_reset();
        reset = 1'b1;
        care0 = '0;
        care1 = '0;
        #1;
        check("rst bus0", 64'(bus0), 64'h00FF_FFFF);
        check("rst bus1", 64'(bus1), 64'h00FF_FFFF);
        check("rst mood0", 64'(mood0), 64'd0);
        check("rst age0", 64'(age0), 64'd0);
        check("rst tick0", 64'(tick0), 64'd0);
        check("rst alarm0", 64'(alarm0), 64'd0);
        check("rst mood1", 64'(mood1), 64'd0);
        check("rst age1", 64'(age1), 64'd0);
        q0.delete();
        q1.delete();
        model_reset();
        alarms0 = 0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (alarm0) alarms0++;
            if (tick0 || q0.size() > 0) begin
                if (q0.size() == 0) begin
                    check("dut0 unexpected tick", 64'(tick0), 64'd0);
                end else begin
                    e0 = q0.pop_front();
                    check("dut0 tick", 64'(tick0), 64'd1);
                    check("dut0 stats", 64'(bus0), 64'(e0.bus));
                    check("dut0 mood", 64'(mood0), 64'(e0.mood));
                    check("dut0 age", 64'(age0), 64'(e0.age));
                    check("dut0 alarm", 64'(alarm0), 64'(e0.alarm));
                end
            end else begin
                check("dut0 idle alarm", 64'(alarm0), 64'd0);
            end
            if (tick1 || q1.size() > 0) begin
                if (q1.size() == 0) begin
                    check("dut1 unexpected tick", 64'(tick1), 64'd0);
                end else begin
                    e1 = q1.pop_front();
                    check("dut1 tick", 64'(tick1), 64'd1);
                    check("dut1 stats", 64'(bus1), 64'(e1.bus));
                    check("dut1 mood", 64'(mood1), 64'(e1.mood));
                    check("dut1 age", 64'(age1), 64'(e1.age));
                    check("dut1 alarm", 64'(alarm1), 64'(e1.alarm));
                end
            end else begin
                check("dut1 idle alarm", 64'(alarm1), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] zmask, r0, r1;
        int pct;
        model_reset();
        @(negedge clk);
        #1;

        // Plain decay down to DEAD; LFSR instance seeded with 0 decays stat0 only on tick 1.
        do_reset();
        run_ticks(1);
        check("dut1 first mask", 64'(bus1), 64'h00FF_FFFE);
        run_ticks(11);
        check("12 ticks stats", 64'(bus0), 64'h0033_3333);
        check("12 ticks mood", 64'(mood0), 64'(WARN));
        check("12 ticks age", 64'(age0), 64'd12);
        run_ticks(3);
        check("15 ticks stats", 64'(bus0), 64'd0);
        check("15 ticks mood", 64'(mood0), 64'(CRIT));
        run_ticks(8);
        check("dead mood", 64'(mood0), 64'(DEAD));
        check("dead age", 64'(age0), 64'd23);
        check("single alarm", 64'(alarms0), 64'd1);
        cycle('1, '0);
        run_ticks(2);
        check("dead frozen stats", 64'(bus0), 64'd0);
        check("dead frozen age", 64'(age0), 64'd23);

        // Saturation at full stat, then care landing on a tick clock at stat 1.
        do_reset();
        cycle(6'b000001, '0);
        repeat (14 * MAXC - 1) cycle('0, '0);
        check("stat0 at 1", 64'(bus0[3:0]), 64'd1);
        repeat (MAXC - 1) cycle('0, '0);
        cycle(6'b000001, '0);
        check("care on tick", 64'(bus0[3:0]), 64'd3);

        // Recover from CRIT, then re-enter: DEAD needs a fresh CRIT_TICKS run.
        do_reset();
        run_ticks(15);
        run_ticks(4);
        zmask = '0;
        for (int i = 0; i < N; i++) zmask[i] = (m_stat[0][i] == 0);
        cycle(zmask, '0);
        repeat (MAXC - 1) cycle('0, '0);
        check("recovered mood", 64'(mood0), 64'(WARN));
        run_ticks(2);
        check("re-crit mood", 64'(mood0), 64'(CRIT));
        run_ticks(CRITT - 1);
        check("still crit", 64'(mood0), 64'(CRIT));
        run_ticks(1);
        check("dead after fresh run", 64'(mood0), 64'(DEAD));
        check("two alarms", 64'(alarms0), 64'd2);

        // Random care with varying intensity.
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            pct = ((c / 200) % 3 == 0) ? 20 : (((c / 200) % 3 == 1) ? 5 : 40);
            for (int i = 0; i < N; i++) begin
                r0[i] = ($urandom_range(0, 99) < pct);
                r1[i] = ($urandom_range(0, 99) < pct);
            end
            cycle(r0, r1);
        end
        cycle('0, '0);
        care0 = '0;
        care1 = '0;
        @(negedge clk);
        #1;
        check("dut0 queue drained", 64'(q0.size()), 64'd0);
        check("dut1 queue drained", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pet_core.md
PET_CORE -- requirements
Module: pet_core

Interface
REQ-001 SHALL have parameter N_STATS, default 6: number of pet statistics (2..8).
REQ-002 SHALL have parameter STAT_W, default 4: width of each statistic (2..8).
REQ-003 SHALL have parameter MAX_COUNT, default 24'd10_000_000: clocks per game tick.
REQ-004 SHALL have parameter CARE_STEP, default 3: amount added per care request.
REQ-005 SHALL have parameter LOW_TH, default 4: a stat strictly below this is "low".
REQ-006 SHALL have parameter CRIT_TICKS, default 8: consecutive ticks with any stat at zero before DEAD.
REQ-007 SHALL have parameter DECAY_MODE, default 1: 0 = every stat decays each tick, 1 = LFSR-masked decay.
REQ-008 SHALL have parameter SEED, default 16'h1000, and parameter TAPS, default 16'hB400 (16-bit Galois LFSR).
REQ-009 clk  input  1  sole clock, rising edge.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 care_req  input  N_STATS  per-stat care pulse, sampled every clock.
REQ-012 stat_bus  output  N_STATS*STAT_W  all stats; stat i at bits [i*STAT_W +: STAT_W].
REQ-013 mood  output  2  FSM state: 0 OK, 1 WARN, 2 CRIT, 3 DEAD.
REQ-014 tick  output  1  one-clock pulse on each game tick.
REQ-015 alarm  output  1  one-clock pulse on entry to CRIT.
REQ-016 age  output  8  ticks survived, saturating.

Function
REQ-017 Prescaler SHALL count 0..MAX_COUNT-1 and assert tick for one clock when it equals MAX_COUNT-1, then wrap to 0.
REQ-018 LFSR SHALL advance exactly once per tick; a zero state (incl. SEED=0) SHALL be forced to 16'h0001.
REQ-019 Decay mask SHALL be all-ones when DECAY_MODE=0, else LFSR bits [N_STATS-1:0] before the advance.
REQ-020 Per clock, each stat SHALL update to sat(old + (care_req[i] ? CARE_STEP : 0) - (tick & mask[i] ? 1 : 0)), saturating at 0 and 2^STAT_W-1, with the sum computed in STAT_W+2 bits.
REQ-021 Care and decay in the same clock SHALL both apply (net CARE_STEP-1); multiple care bits SHALL act independently.
REQ-022 Mood FSM SHALL evaluate only on tick, using post-update stat values.
REQ-023 OK -> WARN when any stat < LOW_TH; WARN -> OK when none is.
REQ-024 OK/WARN -> CRIT when any stat == 0; CRIT -> WARN or OK (per REQ-023) when no stat is 0.
REQ-025 A zero-stat tick counter SHALL increment on each tick in CRIT and clear on leaving CRIT; CRIT -> DEAD when it reaches CRIT_TICKS.
REQ-026 DEAD SHALL be sticky until reset; in DEAD, care_req, decay, age and LFSR SHALL be frozen, and tick SHALL still pulse.
REQ-027 alarm SHALL pulse in the clock after the tick causing entry to CRIT, never on CRIT->CRIT.
REQ-028 age SHALL increment on each tick while not DEAD and saturate at 255.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 On reset: all stats = 2^STAT_W-1, mood = OK, prescaler = 0, LFSR = SEED (REQ-018), age = 0, tick = 0, alarm = 0, zero-tick counter = 0.
REQ-031 Reset asserted mid-tick or in DEAD SHALL restore REQ-030 values immediately; the first tick after release SHALL occur MAX_COUNT clocks later.

Verification (MAX_COUNT=4, DECAY_MODE=0, defaults otherwise)
REQ-032 Release reset, no care -> tick every 4 clocks; after 12 ticks all stats = 3, mood = WARN, age = 12.
REQ-033 Continue 3 more ticks -> stats = 0, mood = CRIT, single alarm pulse; after 8 further ticks mood = DEAD, age frozen at 23.
REQ-034 At stat 15, pulse care_req[0] -> stat 0 stays 15 (saturation); at stat 1 pulse care_req[0] on tick clock -> stat 0 = 3.
REQ-035 In CRIT, pulse care_req on every stat 0 for one clock -> next tick mood leaves CRIT, zero-tick counter clears, no DEAD at later CRIT re-entry until 8 fresh ticks.
REQ-036 In DEAD, pulse all care_req -> stats unchanged; assert reset -> stats 15, mood OK, age 0 asynchronously.
REQ-037 DECAY_MODE=1, SEED=0 -> LFSR reset state 16'h0001, decay mask matches a reference Galois model tick-for-tick.
